// File: rtl/fill_drain.sv
// fill_drain: read side of the fill FIFO. Pops one {addr, line} entry, issues a
// single address phase, streams the line as DATA_W/BEAT_W beats (beat 0 = LSBs),
// then waits for one write response. Only one line is ever in flight.
// Optional feature macro: FILL_DRAIN_CNT_EN adds fill_cnt_o, a saturating count
// of completed line writes.
module fill_drain #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int BEAT_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_fifo_empty_i,
    output logic                     fill_fifo_rden_o,
    input  logic [ADDR_W+DATA_W-1:0] fill_fifo_rdata_i,
    output logic                     dram_awvalid_o,
    input  logic                     dram_awready_i,
    output logic [ADDR_W-1:0]        dram_awaddr_o,
    output logic                     dram_wvalid_o,
    input  logic                     dram_wready_i,
    output logic [BEAT_W-1:0]        dram_wdata_o,
    output logic                     dram_wlast_o,
    input  logic                     dram_bvalid_i,
    output logic                     dram_bready_o,
`ifdef FILL_DRAIN_CNT_EN
    output logic [31:0]              fill_cnt_o,
`endif
    output logic                     busy_o
);

    localparam int NBEATS = DATA_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             beat;
    logic [ADDR_W-1:0]            addr_q;
    logic [NBEATS-1:0][BEAT_W-1:0] data_q;

    // State register; reset abandons any line in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake strobes; rden is gated by rst so every output is low in reset.
    always_comb begin
        state_next       = state;
        fill_fifo_rden_o = 1'b0;
        dram_awvalid_o   = 1'b0;
        dram_wvalid_o    = 1'b0;
        dram_wlast_o     = 1'b0;
        dram_bready_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fill_fifo_empty_i && !rst) begin
                    fill_fifo_rden_o = 1'b1;
                    state_next       = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_AW;
            end
            S_AW: begin
                dram_awvalid_o = 1'b1;
                if (dram_awready_i) begin
                    state_next = S_W;
                end
            end
            S_W: begin
                dram_wvalid_o = 1'b1;
                dram_wlast_o  = (beat == LAST_BEAT);
                if (dram_wready_i && (beat == LAST_BEAT)) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                dram_bready_o = 1'b1;
                if (dram_bvalid_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture the popped entry in the cycle after rden, when the FIFO data is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state == S_LOAD) begin
            addr_q <= fill_fifo_rdata_i[ADDR_W+DATA_W-1:DATA_W];
            data_q <= fill_fifo_rdata_i[DATA_W-1:0];
        end
    end

    // Beat index advances only on an accepted beat and wraps after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if ((state == S_W) && dram_wready_i) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
    end

`ifdef FILL_DRAIN_CNT_EN
    // Completed-line counter, sticking at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_o <= '0;
        end else if (dram_bready_o && dram_bvalid_i && (fill_cnt_o != 32'hFFFF_FFFF)) begin
            fill_cnt_o <= fill_cnt_o + 32'd1;
        end
    end
`endif

    assign dram_awaddr_o = addr_q;
    assign dram_wdata_o  = data_q[beat];
    assign busy_o        = (state != S_IDLE);

endmodule

// File: tb/tb_fill_drain.sv
// tb_fill_drain: randomized and directed bench for fill_drain. A queue-based FIFO
// and a line-level transaction model (pop, address, beats, response) predict
// every output each cycle; directed scenarios add latency/throughput checks.
module tb_fill_drain;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int BEAT_W = 128;
    localparam int NB     = DATA_W / BEAT_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] line;
    } entry_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     fill_fifo_empty_i;
    logic                     fill_fifo_rden_o;
    logic [ADDR_W+DATA_W-1:0] fill_fifo_rdata_i;
    logic                     dram_awvalid_o;
    logic                     dram_awready_i;
    logic [ADDR_W-1:0]        dram_awaddr_o;
    logic                     dram_wvalid_o;
    logic                     dram_wready_i;
    logic [BEAT_W-1:0]        dram_wdata_o;
    logic                     dram_wlast_o;
    logic                     dram_bvalid_i;
    logic                     dram_bready_o;
    logic                     busy_o;
`ifdef FILL_DRAIN_CNT_EN
    logic [31:0]              fill_cnt_o;
`endif

    always #5 clk = ~clk;

    fill_drain #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BEAT_W(BEAT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fill_fifo_empty_i (fill_fifo_empty_i),
        .fill_fifo_rden_o  (fill_fifo_rden_o),
        .fill_fifo_rdata_i (fill_fifo_rdata_i),
        .dram_awvalid_o    (dram_awvalid_o),
        .dram_awready_i    (dram_awready_i),
        .dram_awaddr_o     (dram_awaddr_o),
        .dram_wvalid_o     (dram_wvalid_o),
        .dram_wready_i     (dram_wready_i),
        .dram_wdata_o      (dram_wdata_o),
        .dram_wlast_o      (dram_wlast_o),
        .dram_bvalid_i     (dram_bvalid_i),
        .dram_bready_o     (dram_bready_o),
`ifdef FILL_DRAIN_CNT_EN
        .fill_cnt_o        (fill_cnt_o),
`endif
        .busy_o            (busy_o)
    );

    // FIFO contents and line-level model state
    entry_t fifo_q[$];
    entry_t cur;
    entry_t rdata_next;
    bit     rdata_pending;
    bit     in_flight;
    bit     aw_done;
    int     beats_done;
    int     since_pop;
    int     cnt_model;

    // Stimulus knobs
    bit     rand_mode;
    int     aw_stall;
    int     w_stall_beat;
    int     w_stall_len;
    int     aw_held;
    int     w_held;

    // Observation logs for latency/throughput checks
    int     cycle_n;
    int     rden_cyc[$];
    int     bacc_cyc[$];
    int     busy_obs;
    int     aw_obs;

    int     checks;
    int     passes;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        if (obs === exp_v) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        for (int i = 0; i < (ADDR_W + DATA_W) / 32; i++) begin
            e[i*32 +: 32] = $urandom;
        end
        return e;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check outputs 1 unit later,
    // then advance the model by the handshakes that the next rising edge will see.
    task automatic applyStimulus();
        bit exp_rden, exp_aw, exp_w, exp_b;
        logic [BEAT_W-1:0] exp_wdata;
        @(negedge clk);
        cycle_n++;
        if (in_flight) since_pop++;

        fill_fifo_empty_i = (fifo_q.size() == 0);
        if (rdata_pending) begin
            fill_fifo_rdata_i = rdata_next;
            rdata_pending     = 1'b0;
        end else begin
            fill_fifo_rdata_i = rand_entry();
        end

        exp_rden  = !in_flight && (fifo_q.size() != 0);
        exp_aw    = in_flight && !aw_done && (since_pop >= 2);
        exp_w     = in_flight && aw_done && (beats_done < NB);
        exp_b     = in_flight && aw_done && (beats_done == NB);
        exp_wdata = BEAT_W'(cur.line >> (beats_done * BEAT_W));

        if (rand_mode) begin
            dram_awready_i = ($urandom_range(0, 3) != 0);
            dram_wready_i  = ($urandom_range(0, 3) != 0);
            dram_bvalid_i  = ($urandom_range(0, 2) != 0);
        end else begin
            dram_awready_i = !(exp_aw && (aw_held < aw_stall));
            dram_wready_i  = !(exp_w && (beats_done == w_stall_beat) && (w_held < w_stall_len));
            dram_bvalid_i  = 1'b1;
        end

        #1;
        checkOutput("busy", busy_o, in_flight);
        checkOutput("rden", fill_fifo_rden_o, exp_rden);
        checkOutput("awvalid", dram_awvalid_o, exp_aw);
        checkOutput("wvalid", dram_wvalid_o, exp_w);
        checkOutput("bready", dram_bready_o, exp_b);
        if (exp_aw) checkOutput("awaddr", dram_awaddr_o, cur.addr);
        if (exp_w) begin
            checkOutput("wdata", dram_wdata_o, exp_wdata);
            checkOutput("wlast", dram_wlast_o, (beats_done == NB - 1));
        end
`ifdef FILL_DRAIN_CNT_EN
        checkOutput("fill_cnt", fill_cnt_o, cnt_model);
`endif
        if (busy_o) busy_obs++;
        if (dram_awvalid_o) aw_obs++;

        if (exp_aw && !dram_awready_i) aw_held++;
        if (exp_aw && dram_awready_i) aw_done = 1'b1;
        if (exp_w && !dram_wready_i) w_held++;
        if (exp_w && dram_wready_i) beats_done++;
        if (exp_b && dram_bvalid_i) begin
            in_flight = 1'b0;
            cnt_model++;
            bacc_cyc.push_back(cycle_n);
            aw_held = 0;
            w_held  = 0;
        end
        if (exp_rden) begin
            cur           = fifo_q.pop_front();
            rdata_next    = cur;
            rdata_pending = 1'b1;
            in_flight     = 1'b1;
            aw_done       = 1'b0;
            beats_done    = 0;
            since_pop     = 0;
            rden_cyc.push_back(cycle_n);
        end
    endtask

    task automatic runUntilIdle(input int budget);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while ((in_flight || (fifo_q.size() != 0)) && (n < budget));
        checkOutput("drain_timeout", (in_flight || (fifo_q.size() != 0)), 1'b0);
    endtask

    task automatic clearLogs();
        rden_cyc.delete();
        bacc_cyc.delete();
        busy_obs = 0;
        aw_obs   = 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rden"}, fill_fifo_rden_o, 1'b0);
        checkOutput({tag, "_awvalid"}, dram_awvalid_o, 1'b0);
        checkOutput({tag, "_awaddr"}, dram_awaddr_o, '0);
        checkOutput({tag, "_wvalid"}, dram_wvalid_o, 1'b0);
        checkOutput({tag, "_wdata"}, dram_wdata_o, '0);
        checkOutput({tag, "_wlast"}, dram_wlast_o, 1'b0);
        checkOutput({tag, "_bready"}, dram_bready_o, 1'b0);
        checkOutput({tag, "_busy"}, busy_o, 1'b0);
`ifdef FILL_DRAIN_CNT_EN
        checkOutput({tag, "_cnt"}, fill_cnt_o, 0);
`endif
    endtask

    initial begin
        entry_t e;
        int n;
        checks = 0; passes = 0; cycle_n = 0; cnt_model = 0;
        in_flight = 0; aw_done = 0; beats_done = 0; since_pop = 0; rdata_pending = 0;
        rand_mode = 0; aw_stall = 0; w_stall_beat = -1; w_stall_len = 0; aw_held = 0; w_held = 0;
        cur = '0;

        // Reset with a non-empty FIFO flag: nothing may be popped while in reset
        rst = 1'b1;
        fill_fifo_empty_i = 1'b0;
        fill_fifo_rdata_i = rand_entry();
        dram_awready_i = 1'b0;
        dram_wready_i  = 1'b0;
        dram_bvalid_i  = 1'b0;
        #3;
        checkIdleOutputs("reset");
        @(negedge clk);
        fill_fifo_empty_i = 1'b1;
        rst = 1'b0;

        // Single line, everything ready
        e.addr = 64'h40;
        e.line = {128'h0, 128'h33, 128'h22, 128'h11};
        fifo_q.push_back(e);
        clearLogs();
        runUntilIdle(50);
        checkOutput("single_rden_count", rden_cyc.size(), 1);
        checkOutput("single_latency", bacc_cyc[0] - rden_cyc[0], NB + 3);
        checkOutput("single_busy_cycles", busy_obs, NB + 3);

        // Backpressure: awready low 3 cycles, beat 1 stalled 2 cycles
        fifo_q.push_back(e);
        aw_stall = 3; w_stall_beat = 1; w_stall_len = 2;
        clearLogs();
        runUntilIdle(60);
        checkOutput("bp_rden_count", rden_cyc.size(), 1);
        checkOutput("bp_aw_cycles", aw_obs, 4);
        checkOutput("bp_latency", bacc_cyc[0] - rden_cyc[0], NB + 3 + 3 + 2);
        aw_stall = 0; w_stall_beat = -1; w_stall_len = 0;

        // Empty FIFO for 10 cycles
        clearLogs();
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("empty_busy_cycles", busy_obs, 0);
        checkOutput("empty_rden_count", rden_cyc.size(), 0);

        // Back-to-back lines
        e = rand_entry(); e.addr = 64'h15; fifo_q.push_back(e);
        e = rand_entry(); e.addr = 64'h3;  fifo_q.push_back(e);
        clearLogs();
        runUntilIdle(80);
        checkOutput("b2b_rden_count", rden_cyc.size(), 2);
        if (rden_cyc.size() == 2) checkOutput("b2b_rden_spacing", rden_cyc[1] - rden_cyc[0], NB + 4);

        // Reset in the middle of beat 2
        fifo_q.push_back(rand_entry());
        n = 0;
        while (!(in_flight && aw_done && (beats_done == 2)) && (n < 50)) begin
            applyStimulus();
            n++;
        end
        checkOutput("reach_beat2", (n < 50), 1'b1);
        applyStimulus();
        #1 rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        in_flight = 0; aw_done = 0; beats_done = 0; rdata_pending = 0; cnt_model = 0;
        aw_held = 0; w_held = 0;
        fill_fifo_empty_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearLogs();
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("post_rst_busy", busy_obs, 0);
        checkOutput("post_rst_rden", rden_cyc.size(), 0);

        // Randomized traffic and backpressure
        rand_mode = 1'b1;
        clearLogs();
        for (int i = 0; i < 2500; i++) begin
            if (($urandom_range(0, 7) == 0) && (fifo_q.size() < 4)) fifo_q.push_back(rand_entry());
            applyStimulus();
        end
        runUntilIdle(600);
        checkOutput("rand_lines_done", bacc_cyc.size(), rden_cyc.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
